// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard controller: register map,
// scan-code prefixes, prefix FSM states, the buffered key event and
// STATUS/CTRL bit positions.
package ps2_pkg;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_ERRCNT = 2'd3;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_evt_t;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_HEAD_BRK = 2;
    localparam int ST_HEAD_EXT = 3;
    localparam int ST_OVF      = 4;
    localparam int ST_ERR      = 5;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 7;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous FIFO of key events. A pop and a push in the same cycle both
// take effect, even when full, so the occupancy stays unchanged. Pushes
// into a full FIFO without a simultaneous pop are dropped here; the caller
// records the overflow.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    input  logic     push,
    input  kbd_evt_t push_data,
    input  logic     pop,
    output kbd_evt_t head,
    output logic     full,
    output logic     empty
);

    kbd_evt_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Event storage; contents need no reset since occupancy governs validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: folds E0/F0 prefixes into single key events,
// buffers them in a FIFO and exposes STATUS/DATA/CTRL/ERRCNT registers.
// Optional feature macro PS2_KBD_IRQ_EN adds a level interrupt output
// (CTRL[1] & FIFO non-empty); without it CTRL[1] is reserved.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_code,
    input  logic       rx_error,
    output logic       rx_enable,
    input  logic       bus_sel,
    input  logic       bus_we,
    input  logic [1:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata
`ifdef PS2_KBD_IRQ_EN
    ,
    output logic       irq
`endif
);

    state_t     state;
    state_t     next_state;
    kbd_evt_t   evt;
    logic       evt_push;
    kbd_evt_t   head;
    logic       full;
    logic       empty;
    logic       ctrl_en;
    logic       ovf_sticky;
    logic       err_sticky;
    logic [7:0] errcnt;
    logic [7:0] status_word;
    logic [7:0] ctrl_word;
    logic       wr_ctrl;
    logic       wr_errcnt;
    logic       rd_data;
    logic       flush;
    logic       unused_wdata;
`ifdef PS2_KBD_IRQ_EN
    logic       ctrl_irq_en;
`endif

    assign wr_ctrl   = bus_sel && bus_we && (bus_addr == REG_CTRL);
    assign wr_errcnt = bus_sel && bus_we && (bus_addr == REG_ERRCNT);
    assign rd_data   = bus_sel && !bus_we && (bus_addr == REG_DATA);
    assign flush     = wr_ctrl && bus_wdata[CTRL_FLUSH];
    assign rx_enable = ctrl_en;

`ifdef PS2_KBD_IRQ_EN
    assign unused_wdata = ^bus_wdata[6:2];
`else
    assign unused_wdata = ^{bus_wdata[6:2], bus_wdata[CTRL_IRQ_EN]};
`endif

    // Prefix FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Prefix FSM: accumulate ext/brk flags and emit one event per key code.
    always_comb begin
        next_state = state;
        evt_push   = 1'b0;
        evt        = '{ext: 1'b0, brk: 1'b0, code: rx_code};
        if (flush || !ctrl_en || rx_error) begin
            next_state = S_IDLE;
        end else if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (rx_code == PS2_EXT)      next_state = S_EXT;
                    else if (rx_code == PS2_BRK) next_state = S_BRK;
                    else                         evt_push   = 1'b1;
                end
                S_EXT: begin
                    if (rx_code == PS2_EXT) begin
                        next_state = S_EXT;
                    end else if (rx_code == PS2_BRK) begin
                        next_state = S_EXT_BRK;
                    end else begin
                        evt.ext    = 1'b1;
                        evt_push   = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                S_BRK: begin
                    evt.brk    = 1'b1;
                    evt_push   = 1'b1;
                    next_state = S_IDLE;
                end
                S_EXT_BRK: begin
                    evt.ext    = 1'b1;
                    evt.brk    = 1'b1;
                    evt_push   = 1'b1;
                    next_state = S_IDLE;
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    ps2_evt_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (evt_push),
        .push_data (evt),
        .pop       (rd_data),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // CTRL register; the flush bit is not stored so it always reads back 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en <= 1'b0;
`ifdef PS2_KBD_IRQ_EN
            ctrl_irq_en <= 1'b0;
`endif
        end else if (wr_ctrl) begin
            ctrl_en <= bus_wdata[CTRL_EN];
`ifdef PS2_KBD_IRQ_EN
            ctrl_irq_en <= bus_wdata[CTRL_IRQ_EN];
`endif
        end
    end

    // Sticky flags: overflow on a dropped push, error on any frame error; flush clears both.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ovf_sticky <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            if (evt_push && full && !rd_data) ovf_sticky <= 1'b1;
            if (rx_error)                     err_sticky <= 1'b1;
        end
    end

    // Saturating frame-error counter, cleared by any write to ERRCNT.
    always_ff @(posedge clk) begin
        if (reset || wr_errcnt)                errcnt <= 8'h00;
        else if (rx_error && errcnt != 8'hFF)  errcnt <= errcnt + 8'h01;
    end

    // Assemble STATUS and CTRL read views; head flags are masked when empty.
    always_comb begin
        status_word              = '0;
        status_word[ST_EMPTY]    = empty;
        status_word[ST_FULL]     = full;
        status_word[ST_HEAD_BRK] = head.brk && !empty;
        status_word[ST_HEAD_EXT] = head.ext && !empty;
        status_word[ST_OVF]      = ovf_sticky;
        status_word[ST_ERR]      = err_sticky;
        ctrl_word                = '0;
        ctrl_word[CTRL_EN]       = ctrl_en;
`ifdef PS2_KBD_IRQ_EN
        ctrl_word[CTRL_IRQ_EN]   = ctrl_irq_en;
`endif
    end

    // Registered read data; holds its value when no read is performed.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_rdata <= 8'h00;
        end else if (bus_sel && !bus_we) begin
            case (bus_addr)
                REG_STATUS: bus_rdata <= status_word;
                REG_DATA:   bus_rdata <= empty ? 8'h00 : head.code;
                REG_CTRL:   bus_rdata <= ctrl_word;
                REG_ERRCNT: bus_rdata <= errcnt;
                default:    bus_rdata <= bus_rdata;
            endcase
        end
    end

`ifdef PS2_KBD_IRQ_EN
    // Level interrupt registered from the current enable and FIFO occupancy.
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= ctrl_irq_en && !empty;
    end
`endif

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl with a queue-based reference model.
// Interrupt checks are compiled in when PS2_KBD_IRQ_EN is defined.
module tb_ps2_kbd_ctrl;
    import ps2_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef PS2_KBD_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_code = 8'h00;
    logic       rx_error = 1'b0;
    logic       rx_enable;
    logic       bus_sel = 1'b0;
    logic       bus_we = 1'b0;
    logic [1:0] bus_addr = 2'd0;
    logic [7:0] bus_wdata = 8'h00;
    logic [7:0] bus_rdata;
`ifdef PS2_KBD_IRQ_EN
    logic       irq;
`endif

    int checks = 0;
    int fails  = 0;

    // Reference model state
    logic [9:0] m_q[$];
    bit         m_en, m_irq_en, m_ext, m_brk, m_ovf, m_err;
    int         m_errcnt;

    ps2_kbd_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_code   (rx_code),
        .rx_error  (rx_error),
        .rx_enable (rx_enable),
        .bus_sel   (bus_sel),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
`ifdef PS2_KBD_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- reference model ----------------
    task automatic model_clear_all();
        m_q.delete();
        m_en = 0; m_irq_en = 0; m_ext = 0; m_brk = 0;
        m_ovf = 0; m_err = 0; m_errcnt = 0;
    endtask

    task automatic model_rx(input logic [7:0] c);
        if (!m_en) begin
            m_ext = 0; m_brk = 0;
        end else if (c == 8'hE0 && !m_brk) begin
            m_ext = 1;
        end else if (c == 8'hF0 && !m_brk) begin
            m_brk = 1;
        end else begin
            if (m_q.size() == DEPTH) m_ovf = 1;
            else m_q.push_back({m_ext, m_brk, c});
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic model_pop(output logic [7:0] d);
        logic [9:0] e;
        if (m_q.size() == 0) d = 8'h00;
        else begin
            e = m_q.pop_front();
            d = e[7:0];
        end
    endtask

    function automatic logic [7:0] model_status();
        logic [7:0] s;
        s = 8'h00;
        s[0] = (m_q.size() == 0);
        s[1] = (m_q.size() == DEPTH);
        if (m_q.size() != 0) begin
            s[2] = m_q[0][8];
            s[3] = m_q[0][9];
        end
        s[4] = m_ovf;
        s[5] = m_err;
        return s;
    endfunction

    function automatic logic [7:0] model_ctrl();
        return {6'b0, HAS_IRQ ? m_irq_en : 1'b0, m_en};
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic do_reset();
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        model_clear_all();
    endtask

    task automatic send_code(input logic [7:0] c);
        @(negedge clk); rx_valid = 1; rx_code = c;
        @(negedge clk); rx_valid = 0;
        model_rx(c);
    endtask

    task automatic send_error();
        @(negedge clk); rx_error = 1;
        @(negedge clk); rx_error = 0;
        m_err = 1;
        if (m_errcnt != 255) m_errcnt++;
        m_ext = 0; m_brk = 0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk); bus_sel = 1; bus_we = 1; bus_addr = a; bus_wdata = d;
        @(negedge clk); bus_sel = 0; bus_we = 0;
        if (a == REG_CTRL) begin
            m_en = d[0]; m_irq_en = d[1];
            if (!d[0] || d[7]) begin m_ext = 0; m_brk = 0; end
            if (d[7]) begin m_q.delete(); m_ovf = 0; m_err = 0; end
        end
        if (a == REG_ERRCNT) m_errcnt = 0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk); bus_sel = 1; bus_we = 0; bus_addr = a;
        @(negedge clk); bus_sel = 0;
        d = bus_rdata;
    endtask

    function automatic logic [7:0] rand_plain();
        return 8'($urandom_range(0, 8'hDF));
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] v;
        do_reset();
        checks++; if (bus_rdata !== 8'h00) begin $display("[TB] FAIL reset_rdata: got %h required 00", bus_rdata); fails++; end
        checks++; if (rx_enable !== 1'b0) begin $display("[TB] FAIL reset_rx_enable: got %b required 0", rx_enable); fails++; end
`ifdef PS2_KBD_IRQ_EN
        checks++; if (irq !== 1'b0) begin $display("[TB] FAIL reset_irq: got %b required 0", irq); fails++; end
`endif
        bus_read(REG_STATUS, v);
        checks++; if (v !== 8'h01) begin $display("[TB] FAIL reset_status: got %h required 01", v); fails++; end
        bus_read(REG_CTRL, v);
        checks++; if (v !== 8'h00) begin $display("[TB] FAIL reset_ctrl: got %h required 00", v); fails++; end
        bus_read(REG_ERRCNT, v);
        checks++; if (v !== 8'h00) begin $display("[TB] FAIL reset_errcnt: got %h required 00", v); fails++; end
    endtask

    task automatic test_basic();
        logic [7:0] v, e;
        bus_write(REG_CTRL, 8'h03);
        checks++; if (rx_enable !== 1'b1) begin $display("[TB] FAIL enable_rx: got %b required 1", rx_enable); fails++; end
        bus_read(REG_CTRL, v);
        checks++; if (v !== model_ctrl()) begin $display("[TB] FAIL ctrl_readback: got %h required %h", v, model_ctrl()); fails++; end
        bus_write(REG_CTRL, 8'h01);
        send_code(8'h1C);
        bus_read(REG_STATUS, v);
        checks++; if (v !== 8'h00) begin $display("[TB] FAIL basic_status: got %h required 00", v); fails++; end
        model_pop(e);
        bus_read(REG_DATA, v);
        checks++; if (v !== 8'h1C) begin $display("[TB] FAIL basic_data: got %h required 1c", v); fails++; end
        bus_write(REG_DATA, 8'h55);
        checks++; if (bus_rdata !== 8'h1C) begin $display("[TB] FAIL rdata_hold: got %h required 1c", bus_rdata); fails++; end
        bus_read(REG_STATUS, v);
        checks++; if (v !== 8'h01) begin $display("[TB] FAIL basic_status_after: got %h required 01", v); fails++; end
    endtask

    task automatic test_prefix();
        logic [7:0] v, e;
        send_code(8'hE0); send_code(8'hF0); send_code(8'h75);
        bus_read(REG_STATUS, v);
        checks++; if (v !== 8'h0C) begin $display("[TB] FAIL prefix_status: got %h required 0c", v); fails++; end
        model_pop(e);
        bus_read(REG_DATA, v);
        checks++; if (v !== e) begin $display("[TB] FAIL prefix_data: got %h required %h", v, e); fails++; end
        bus_read(REG_STATUS, v);
        checks++; if (v !== 8'h01) begin $display("[TB] FAIL prefix_single: got %h required 01", v); fails++; end
    endtask

    task automatic test_overflow();
        logic [7:0] v, e;
        for (int i = 0; i < DEPTH + 1; i++) send_code(rand_plain());
        bus_read(REG_STATUS, v);
        checks++; if (v !== (8'h12 | model_status())) begin $display("[TB] FAIL ovf_status: got %h required %h", v, model_status()); fails++; end
        for (int i = 0; i < DEPTH / 2; i++) begin
            model_pop(e);
            bus_read(REG_DATA, v);
            checks++; if (v !== e) begin $display("[TB] FAIL ovf_order[%0d]: got %h required %h", i, v, e); fails++; end
        end
        bus_write(REG_CTRL, 8'h81);
        bus_read(REG_STATUS, v);
        checks++; if (v !== 8'h01) begin $display("[TB] FAIL flush_status: got %h required 01", v); fails++; end
        bus_read(REG_CTRL, v);
        checks++; if (v !== 8'h01) begin $display("[TB] FAIL flush_selfclear: got %h required 01", v); fails++; end
    endtask

    task automatic test_error();
        logic [7:0] v, e;
        send_code(8'hF0); send_error(); send_code(8'h1C);
        bus_read(REG_STATUS, v);
        checks++; if (v !== model_status()) begin $display("[TB] FAIL err_status: got %h required %h", v, model_status()); fails++; end
        model_pop(e);
        bus_read(REG_DATA, v);
        checks++; if (v !== 8'h1C) begin $display("[TB] FAIL err_data: got %h required 1c", v); fails++; end
        bus_read(REG_ERRCNT, v);
        checks++; if (v !== 8'h01) begin $display("[TB] FAIL errcnt_one: got %h required 01", v); fails++; end
        bus_write(REG_ERRCNT, 8'h00);
        bus_read(REG_ERRCNT, v);
        checks++; if (v !== 8'h00) begin $display("[TB] FAIL errcnt_clear: got %h required 00", v); fails++; end
        for (int i = 0; i < 300; i++) send_error();
        bus_read(REG_ERRCNT, v);
        checks++; if (v !== 8'hFF || m_errcnt != 255) begin $display("[TB] FAIL errcnt_sat: got %h required ff", v); fails++; end
        bus_write(REG_CTRL, 8'h81);
        bus_read(REG_STATUS, v);
        checks++; if (v !== 8'h01) begin $display("[TB] FAIL err_flush: got %h required 01", v); fails++; end
    endtask

    task automatic test_empty_read();
        logic [7:0] v, e, c;
        bus_read(REG_DATA, v);
        checks++; if (v !== 8'h00) begin $display("[TB] FAIL empty_data: got %h required 00", v); fails++; end
        c = rand_plain();
        send_code(c);
        model_pop(e);
        bus_read(REG_DATA, v);
        checks++; if (v !== c) begin $display("[TB] FAIL empty_nomove: got %h required %h", v, c); fails++; end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] v, e, c;
        bus_write(REG_CTRL, 8'h81);
        for (int i = 0; i < DEPTH; i++) send_code(rand_plain());
        c = rand_plain();
        model_pop(e);
        @(negedge clk); rx_valid = 1; rx_code = c; bus_sel = 1; bus_we = 0; bus_addr = REG_DATA;
        @(negedge clk); rx_valid = 0; bus_sel = 0;
        v = bus_rdata;
        model_rx(c);
        checks++; if (v !== e) begin $display("[TB] FAIL pushpop_data: got %h required %h", v, e); fails++; end
        bus_read(REG_STATUS, v);
        checks++; if (v !== model_status()) begin $display("[TB] FAIL pushpop_status: got %h required %h", v, model_status()); fails++; end
        for (int i = 0; i < DEPTH; i++) begin
            model_pop(e);
            bus_read(REG_DATA, v);
            checks++; if (v !== e) begin $display("[TB] FAIL pushpop_order[%0d]: got %h required %h", i, v, e); fails++; end
        end
    endtask

    task automatic test_disable();
        logic [7:0] v, e;
        send_code(8'h11); send_code(8'hE0); send_code(8'h22);
        bus_write(REG_CTRL, 8'h00);
        checks++; if (rx_enable !== 1'b0) begin $display("[TB] FAIL disable_rx: got %b required 0", rx_enable); fails++; end
        for (int i = 0; i < 2; i++) begin
            model_pop(e);
            bus_read(REG_DATA, v);
            checks++; if (v !== e) begin $display("[TB] FAIL disable_drain[%0d]: got %h required %h", i, v, e); fails++; end
        end
        bus_write(REG_CTRL, 8'h01);
    endtask

    task automatic test_random();
        logic [7:0] v, e, c;
        int r;
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 19);
            if (r < 11) begin
                case ($urandom_range(0, 3))
                    0: c = 8'hE0;
                    1: c = 8'hF0;
                    default: c = 8'($urandom_range(0, 255));
                endcase
                send_code(c);
            end else if (r < 16) begin
                model_pop(e);
                bus_read(REG_DATA, v);
                checks++; if (v !== e) begin $display("[TB] FAIL rand_data[%0d]: got %h required %h", i, v, e); fails++; end
            end else if (r < 19) begin
                bus_read(REG_STATUS, v);
                checks++; if (v !== model_status()) begin $display("[TB] FAIL rand_status[%0d]: got %h required %h", i, v, model_status()); fails++; end
            end else begin
                send_error();
            end
        end
        bus_read(REG_ERRCNT, v);
        checks++; if (v !== 8'(m_errcnt)) begin $display("[TB] FAIL rand_errcnt: got %h required %h", v, 8'(m_errcnt)); fails++; end
    endtask

`ifdef PS2_KBD_IRQ_EN
    task automatic test_irq();
        logic [7:0] v, e;
        bus_write(REG_CTRL, 8'h83);
        send_code(8'h2A);
        checks++; if (irq !== 1'b0) begin $display("[TB] FAIL irq_early: got %b required 0", irq); fails++; end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin $display("[TB] FAIL irq_assert: got %b required 1", irq); fails++; end
        model_pop(e);
        bus_read(REG_DATA, v);
        checks++; if (irq !== 1'b1) begin $display("[TB] FAIL irq_hold: got %b required 1", irq); fails++; end
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin $display("[TB] FAIL irq_deassert: got %b required 0", irq); fails++; end
    endtask
`endif

    task automatic test_reset_mid();
        logic [7:0] v, e;
        bus_write(REG_CTRL, 8'h01);
        send_code(8'h33);
        send_error();
        bus_read(REG_CTRL, v);
        send_code(8'hE0);
        do_reset();
        checks++; if (bus_rdata !== 8'h00) begin $display("[TB] FAIL mid_rdata: got %h required 00", bus_rdata); fails++; end
        checks++; if (rx_enable !== 1'b0) begin $display("[TB] FAIL mid_rx_enable: got %b required 0", rx_enable); fails++; end
        bus_read(REG_STATUS, v);
        checks++; if (v !== 8'h01) begin $display("[TB] FAIL mid_status: got %h required 01", v); fails++; end
        bus_read(REG_ERRCNT, v);
        checks++; if (v !== 8'h00) begin $display("[TB] FAIL mid_errcnt: got %h required 00", v); fails++; end
        bus_write(REG_CTRL, 8'h01);
        send_code(8'h75);
        bus_read(REG_STATUS, v);
        checks++; if (v !== 8'h00) begin $display("[TB] FAIL mid_prefix_dropped: got %h required 00", v); fails++; end
        model_pop(e);
        bus_read(REG_DATA, v);
        checks++; if (v !== 8'h75) begin $display("[TB] FAIL mid_data: got %h required 75", v); fails++; end
    endtask

    initial begin
        model_clear_all();
        test_reset();
        test_basic();
        test_prefix();
        test_overflow();
        test_error();
        test_empty_read();
        test_full_pushpop();
        test_disable();
        test_random();
`ifdef PS2_KBD_IRQ_EN
        test_irq();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
